// File: rtl/fir_driver_if.sv
// fir_driver_if: bundles the three signal groups around fir_driver.
//   upstream   : s_data, s_valid -> ; s_ready <-
//   control    : flush -> ; busy <-
//   FIR link   : fir_data_in, fir_valid_in <- ; fir_data_out ->
//   downstream : m_data, m_valid <- ; m_ready ->
// The slave modport is the driver's view; master is the environment's view.
interface fir_driver_if #(
  parameter int DW = 8,
  parameter int OW = 15
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          flush;
  logic          busy;
  logic [DW-1:0] fir_data_in;
  logic          fir_valid_in;
  logic [OW-1:0] fir_data_out;
  logic [OW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport slave (
    input  s_data, s_valid, flush, fir_data_out, m_ready,
    output s_ready, busy, fir_data_in, fir_valid_in, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, flush, fir_data_out, m_ready,
    input  s_ready, busy, fir_data_in, fir_valid_in, m_data, m_valid
  );
endinterface

// File: rtl/fir_driver.sv
// fir_driver: upstream controller for a 3-tap time-multiplexed FIR.
// Buffers samples in a small FIFO, issues them to the FIR as single-cycle
// valid pulses (one transaction in flight), captures each result on the one
// cycle it is present and offers it downstream with valid/ready. After reset
// the FIR tap history is primed with TAPS zeros (results discarded); a flush
// pulse issues TAPS zeros whose results are delivered.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : fir_driver_if.slave (s_*, flush/busy, fir_*, m_*)
module fir_driver #(
  parameter int DW         = 8,
  parameter int OW         = 15,
  parameter int TAPS       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME      = 1
) (
  input logic         clk,
  input logic         rst,
  fir_driver_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int ZW = $clog2(TAPS + 1);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [ZW-1:0] ZLAST    = TAPS[ZW-1:0];

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_PRIME,
    ST_IDLE,
    ST_WAIT,
    ST_CAPT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [ZW-1:0] zcnt_q, zcnt_d;
  logic          prime_q, prime_d;
  logic          fpend_q, fpend_d;
  logic          m_valid_q, m_valid_d;
  logic [OW-1:0] m_data_q, m_data_d;
  logic          fvin_q, fvin_d;
  logic [DW-1:0] fdin_q, fdin_d;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;

  logic full, empty, push, pop, out_free, issue, issue_zero;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign push     = bus.s_valid & ~full;
  assign out_free = ~m_valid_q | bus.m_ready;

  assign bus.s_ready      = ~full;
  assign bus.busy         = prime_q | fpend_q;
  assign bus.fir_data_in  = fdin_q;
  assign bus.fir_valid_in = fvin_q;
  assign bus.m_data       = m_data_q;
  assign bus.m_valid      = m_valid_q;

  // Sample storage; contents need no reset since cnt_q gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    zcnt_d     = zcnt_q;
    prime_d    = prime_q;
    fpend_d    = fpend_q | bus.flush;
    m_valid_d  = m_valid_q & ~bus.m_ready;
    m_data_d   = m_data_q;
    fvin_d     = 1'b0;
    fdin_d     = fdin_q;
    pop        = 1'b0;
    issue      = 1'b0;
    issue_zero = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (wcnt_q == 2'd3) begin
          state_d = ST_PRIME;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      ST_PRIME: begin
        issue      = 1'b1;
        issue_zero = 1'b1;
      end
      ST_IDLE: begin
        // Zero sequence (flush) outranks queued samples.
        if (out_free) begin
          if (fpend_q) begin
            issue      = 1'b1;
            issue_zero = 1'b1;
          end else if (!empty) begin
            issue = 1'b1;
            pop   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Counts the FIR sampling edge plus its three MAC edges.
        if (wcnt_q == 2'd3) state_d = ST_CAPT;
        wcnt_d = wcnt_q + 2'd1;
      end
      ST_CAPT: begin
        if (prime_q) begin
          if (zcnt_q == ZLAST) begin
            prime_d = 1'b0;
            zcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PRIME;
          end
        end else begin
          // Output register is free here: issue required it to be.
          m_valid_d = 1'b1;
          m_data_d  = bus.fir_data_out;
          if (fpend_q && zcnt_q == ZLAST) begin
            fpend_d = 1'b0;
            zcnt_d  = '0;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      fvin_d  = 1'b1;
      fdin_d  = issue_zero ? '0 : mem[rd_q];
      state_d = ST_WAIT;
      wcnt_d  = '0;
      if (issue_zero) zcnt_d = zcnt_q + ZW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= (PRIME != 0) ? ST_SETTLE : ST_IDLE;
      wcnt_q    <= '0;
      zcnt_q    <= '0;
      prime_q   <= (PRIME != 0);
      fpend_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      fvin_q    <= 1'b0;
      fdin_q    <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      zcnt_q    <= zcnt_d;
      prime_q   <= prime_d;
      fpend_q   <= fpend_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      fvin_q    <= fvin_d;
      fdin_q    <= fdin_d;
    end
  end
endmodule

// File: tb/tb_fir_driver.sv
// tb_fir_driver: drives fir_driver against a behavioural 3-tap FIR
// (coefficients 5, -5, 15) and checks results through a scoreboard queue.
module tb_fir_driver;
  localparam int DW = 8;
  localparam int OW = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_driver_if #(.DW(DW), .OW(OW)) bus ();

  fir_driver #(
    .DW(DW), .OW(OW), .TAPS(3), .FIFO_DEPTH(4), .PRIME(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] last_out = '0;
  int hist[3] = '{default: 0};

  int  vin_cnt = 0, mv_rises = 0, cyc = 0, last_vin = 0;
  bit  have_vin = 0, mv_prev = 0, prime_win = 0, rand_rdy = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: y[n] = 5*x[n] - 5*x[n-1] + 15*x[n-2], truncated to OW bits.
  function automatic void model_reset();
    hist = '{default: 0};
  endfunction

  function automatic void model_feed(input int x, input bit deliver);
    int y;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
    y = 5 * hist[0] - 5 * hist[1] + 15 * hist[2];
    if (deliver) exp_q.push_back(y[OW-1:0]);
  endfunction

  // FIR stand-in: samples valid_in at edge E, result present only between
  // edges E+3 and E+4; any other cycle carries random junk.
  int fh[3] = '{default: 0};
  int fk = 0;
  int fy = 0;
  initial forever begin
    @(posedge clk);
    bus.fir_data_out <= OW'($urandom);
    if (fk > 0) begin
      fk--;
      if (fk == 0) bus.fir_data_out <= fy[OW-1:0];
    end
    if (bus.fir_valid_in === 1'b1) begin
      fh[2] = fh[1];
      fh[1] = fh[0];
      fh[0] = int'($signed(bus.fir_data_in));
      fy = 5 * fh[0] - 5 * fh[1] + 15 * fh[2];
      fk = 3;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard compare, issue spacing, issue-to-result latency.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      have_vin = 0;
      mv_prev  = 0;
    end else begin
      if (bus.fir_valid_in) begin
        vin_cnt++;
        if (prime_win) chk("prime_sample_zero", int'(bus.fir_data_in), 0);
        if (have_vin) begin
          checks++;
          if (cyc - last_vin < 5) begin
            errors++;
            $display("FAIL issue_spacing: %0d cycles between fir_valid_in pulses, need >= 5",
                     cyc - last_vin);
          end
        end
        have_vin = 1;
        last_vin = cyc;
      end
      if (prime_win) chk("m_valid_low_in_prime", int'(bus.m_valid), 0);
      if (bus.m_valid && !mv_prev) begin
        mv_rises++;
        if (have_vin) chk("issue_to_m_valid_edges", cyc - last_vin, 5);
      end
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_m_valid: m_data 0x%0h with no result outstanding", bus.m_data);
        end else begin
          chk("m_data", int'(bus.m_data), int'(exp_q[0]));
          if (bus.m_ready) begin
            last_out = bus.m_data;
            void'(exp_q.pop_front());
          end
        end
      end
      mv_prev = bus.m_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input int x, input bit feed);
    int n = 0;
    bit acc = 0;
    bus.s_data  = DW'(x);
    bus.s_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.s_ready;
      step();
      n++;
    end
    bus.s_valid = 1'b0;
    chk("push_accepted", int'(acc), 1);
    if (acc && feed) model_feed(x, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk("results_drained", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("busy_after_flush", int'(bus.busy), 1);
  endtask

  task automatic do_reset();
    int n = 0;
    int v0;
    #3 rst = 1'b1;
    #1;
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_fir_valid_in", int'(bus.fir_valid_in), 0);
    chk("rst_fir_data_in", int'(bus.fir_data_in), 0);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_s_ready", int'(bus.s_ready), 1);
    exp_q.delete();
    model_reset();
    bus.s_valid = 1'b0;
    bus.flush   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    prime_win = 1;
    v0 = vin_cnt;
    while (bus.busy && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    prime_win = 0;
    chk("prime_busy_clears", int'(bus.busy), 0);
    chk("prime_pulse_count", vin_cnt - v0, 3);
    checks++;
    if (n < 19 || n > 24) begin
      errors++;
      $display("FAIL prime_busy_length: busy held %0d cycles, need 19..24", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, mv0, x6, a, b, c, n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // 1,2,3 back-to-back -> 5, 5, 20
    push(1, 1); push(2, 1); push(3, 1);
    wait_drain();
    chk("seq_last_result", int'(last_out), 20);

    // idle flush delivers three results, clears history, then -4 -> -20
    pulse_flush();
    repeat (3) model_feed(0, 1'b1);
    wait_drain();
    chk("flush_busy_cleared", int'(bus.busy), 0);
    push(-4, 1);
    wait_drain();
    chk("neg4_result", int'(last_out), 'h7FEC);

    // backpressure: one in flight, four stored, sixth blocked
    bus.m_ready = 1'b0;
    v0 = vin_cnt;
    for (int i = 0; i < 5; i++) push($urandom_range(0, 255) - 128, 1);
    chk("s_ready_low_when_full", int'(bus.s_ready), 0);
    x6 = $urandom_range(0, 255) - 128;
    bus.s_data  = DW'(x6);
    bus.s_valid = 1'b1;
    idle(20);
    chk("s_ready_still_low", int'(bus.s_ready), 0);
    chk("single_issue_while_held", vin_cnt - v0, 1);
    chk("m_valid_held", int'(bus.m_valid), 1);
    bus.m_ready = 1'b1;
    push(x6, 1);
    wait_drain();

    // flush mid-WAIT with two samples queued
    idle(3);
    mv0 = mv_rises;
    a = $urandom_range(0, 255) - 128;
    b = $urandom_range(0, 255) - 128;
    c = $urandom_range(0, 255) - 128;
    push(a, 1); push(b, 0); push(c, 0);
    pulse_flush();
    repeat (3) model_feed(0, 1'b1);
    model_feed(b, 1'b1);
    model_feed(c, 1'b1);
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    chk("results_when_busy_falls", mv_rises - mv0, 4);
    wait_drain();

    // randomized samples, gaps and downstream stalls
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      push($urandom_range(0, 255) - 128, 1);
      idle($urandom_range(0, 2));
    end
    rand_rdy = 0;
    bus.m_ready = 1'b1;
    wait_drain();

    // reset during WAIT, then reset with a held result
    push(9, 1);
    idle(2);
    do_reset();
    bus.m_ready = 1'b0;
    push(11, 1);
    n = 0;
    while (!bus.m_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held_before_reset", int'(bus.m_valid), 1);
    do_reset();
    bus.m_ready = 1'b1;
    push(7, 1);
    wait_drain();
    chk("post_reset_result", int'(last_out), 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
